// File: rtl/sd_card_block_writer.sv
// Byte FIFO that drains fixed-size blocks into an SD card block-write port.
// Tracks block index, addressing mode, write errors and producer overflow.
module sd_card_block_writer #(
  parameter int FIFO_DEPTH  = 1024,
  parameter int BLOCK_BYTES = 512,
  parameter int START_BLOCK = 0,
  parameter int CNT_W       = 16
) (
  input  logic                          clk210_p,
  input  logic                          reset_p,
  input  logic [7:0]                    wr_data_p,
  input  logic                          wr_en_p,
  output logic                          fifo_full_p,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_p,
  input  logic                          sd_card_initialized_p,
  input  logic                          sd_card_init_error_p,
  input  logic                          sd_card_ccs_bit_p,
  output logic                          blk_wr_req_p,
  output logic [31:0]                   blk_wr_addr_p,
  input  logic                          blk_wr_ack_p,
  output logic                          byte_valid_p,
  output logic [7:0]                    byte_data_p,
  input  logic                          byte_ready_p,
  input  logic                          blk_wr_done_p,
  input  logic                          blk_wr_error_p,
  output logic                          busy_p,
  output logic                          error_p,
  output logic [31:0]                   blocks_written_p,
  output logic [CNT_W-1:0]              overflow_cnt_p
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(BLOCK_BYTES + 1);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   BB_C    = (AW+1)'(BLOCK_BYTES);
  localparam logic [31:0]   BB32    = 32'(BLOCK_BYTES);
  localparam logic [BW-1:0] LAST_C  = BW'(BLOCK_BYTES - 1);

  typedef enum logic [2:0] {
    S_WAIT_INIT, S_IDLE, S_REQ, S_STREAM, S_WAIT_DONE, S_ERROR
  } state_t;

  state_t r_state, w_next;

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [AW:0]      r_wptr, r_rptr;
  logic [CNT_W-1:0] r_ovf;
  logic [BW-1:0]    r_byte_cnt;
  logic [31:0]      r_blk_idx, r_blocks, r_addr;
  logic             r_ccs, r_error;

  logic [AW:0] w_count;
  logic        w_full, w_push, w_pop, w_last_pop, w_err_any, w_done_ok;
  logic [31:0] w_addr;

  assign w_count    = r_wptr - r_rptr;
  assign w_full     = (w_count == DEPTH_C);
  assign w_push     = wr_en_p & ~w_full;
  assign w_pop      = (r_state == S_STREAM) & byte_ready_p;
  assign w_last_pop = w_pop & (r_byte_cnt == LAST_C);
  assign w_err_any  = r_error | sd_card_init_error_p;
  assign w_done_ok  = (r_state == S_WAIT_DONE) & blk_wr_done_p & ~blk_wr_error_p;
  assign w_addr     = r_ccs ? r_blk_idx : r_blk_idx * BB32;

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk210_p) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= wr_data_p;
  end

  always_ff @(posedge clk210_p) begin
    if (reset_p) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (wr_en_p & w_full & ~(&r_ovf)) r_ovf <= r_ovf + 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_WAIT_INIT: begin
        if (sd_card_init_error_p)       w_next = S_ERROR;
        else if (sd_card_initialized_p) w_next = S_IDLE;
      end
      S_IDLE: begin
        if (w_err_any)             w_next = S_ERROR;
        else if (w_count >= BB_C)  w_next = S_REQ;
      end
      S_REQ:    if (blk_wr_ack_p) w_next = S_STREAM;
      S_STREAM: if (w_last_pop)   w_next = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (blk_wr_error_p)     w_next = S_ERROR;
        else if (blk_wr_done_p) w_next = w_err_any ? S_ERROR : S_IDLE;
      end
      S_ERROR: w_next = S_ERROR;
      default: w_next = S_WAIT_INIT;
    endcase
  end

  always_ff @(posedge clk210_p) begin
    if (reset_p) begin
      r_state    <= S_WAIT_INIT;
      r_ccs      <= 1'b0;
      r_error    <= 1'b0;
      r_blk_idx  <= 32'(START_BLOCK);
      r_blocks   <= '0;
      r_addr     <= '0;
      r_byte_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_WAIT_INIT && w_next == S_IDLE) r_ccs <= sd_card_ccs_bit_p;
      if (sd_card_init_error_p) r_error <= 1'b1;
      if (r_state == S_WAIT_DONE && blk_wr_error_p) r_error <= 1'b1;
      if (r_state == S_IDLE && w_next == S_REQ) r_addr <= w_addr;
      if (w_done_ok) begin
        r_blk_idx <= r_blk_idx + 32'd1;
        r_blocks  <= r_blocks + 32'd1;
      end
      if (w_last_pop)  r_byte_cnt <= '0;
      else if (w_pop)  r_byte_cnt <= r_byte_cnt + 1'b1;
    end
  end

  assign fifo_full_p      = w_full;
  assign fifo_count_p     = w_count;
  assign blk_wr_req_p     = (r_state == S_REQ);
  assign blk_wr_addr_p    = r_addr;
  assign byte_valid_p     = (r_state == S_STREAM);
  assign byte_data_p      = r_mem[r_rptr[AW-1:0]];
  assign busy_p           = (r_state != S_IDLE) && (r_state != S_WAIT_INIT);
  assign error_p          = r_error;
  assign blocks_written_p = r_blocks;
  assign overflow_cnt_p   = r_ovf;

endmodule

// File: doc/sd_card_block_writer.md
SD_CARD_BLOCK_WRITER -- requirements
Module: sd_card_block_writer

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 1024: byte FIFO depth; power of two; at least BLOCK_BYTES.
REQ-002 The block SHALL have parameter BLOCK_BYTES, default 512: bytes per SD write block.
REQ-003 The block SHALL have parameter START_BLOCK, default 0: first SD block index written after reset.
REQ-004 The block SHALL have parameter CNT_W, default 16: width of the overflow counter.
REQ-005 The block SHALL run on one clock; reset is synchronous and active-high.
REQ-006 clk210_p  in  1  sole clock; all logic on its rising edge.
REQ-007 reset_p  in  1  synchronous, active-high reset.
REQ-008 wr_data_p  in  8  producer byte.
REQ-009 wr_en_p  in  1  producer write strobe.
REQ-010 fifo_full_p  out  1  FIFO holds FIFO_DEPTH bytes.
REQ-011 fifo_count_p  out  log2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-012 sd_card_initialized_p  in  1  controller initialisation complete.
REQ-013 sd_card_init_error_p  in  1  controller initialisation failed.
REQ-014 sd_card_ccs_bit_p  in  1  card capacity status: 1 = block addressing, 0 = byte addressing.
REQ-015 blk_wr_req_p  out  1  block-write command request.
REQ-016 blk_wr_addr_p  out  32  SD address of the requested block.
REQ-017 blk_wr_ack_p  in  1  controller accepts the request.
REQ-018 byte_valid_p  out  1  outgoing data byte valid.
REQ-019 byte_data_p  out  8  outgoing data byte.
REQ-020 byte_ready_p  in  1  controller consumes the byte.
REQ-021 blk_wr_done_p  in  1  one-cycle pulse: block write finished.
REQ-022 blk_wr_error_p  in  1  one-cycle pulse: block write failed (bad data response or timeout).
REQ-023 busy_p  out  1  state not IDLE and not WAIT_INIT.
REQ-024 error_p  out  1  sticky error.
REQ-025 blocks_written_p  out  32  count of successfully written blocks.
REQ-026 overflow_cnt_p  out  CNT_W  count of bytes dropped on write-while-full.

Function
REQ-027 FIFO write: when wr_en_p=1 and not full, the byte SHALL be stored; when full, it SHALL be dropped and overflow_cnt_p SHALL increment, saturating at all-ones.
REQ-028 A simultaneous FIFO write and read in one cycle SHALL leave fifo_count_p unchanged; a write while full SHALL be dropped even if a read occurs in the same cycle.
REQ-029 Read and write pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be exact at the wrap.
REQ-030 The FSM SHALL have states WAIT_INIT, IDLE, REQ, STREAM, WAIT_DONE and ERROR.
REQ-031 WAIT_INIT SHALL go to ERROR if sd_card_init_error_p=1, else to IDLE if sd_card_initialized_p=1; sd_card_ccs_bit_p SHALL be latched on that transition.
REQ-032 IDLE SHALL go to REQ when fifo_count_p >= BLOCK_BYTES.
REQ-033 In REQ, blk_wr_req_p SHALL be 1 and blk_wr_addr_p SHALL be held stable.
REQ-034 The REQ address SHALL be the block index when ccs=1 and block index × BLOCK_BYTES (truncated to 32 bits) when ccs=0.
REQ-035 REQ SHALL go to STREAM on the cycle blk_wr_ack_p=1; blk_wr_req_p SHALL drop the cycle after the ack.
REQ-036 In STREAM, byte_data_p SHALL be the FIFO head, combinationally available with zero read latency, and byte_valid_p SHALL be 1.
REQ-037 In STREAM, a byte SHALL be popped when byte_valid_p and byte_ready_p are both 1; after BLOCK_BYTES pops the FSM SHALL go to WAIT_DONE with byte_valid_p=0.
REQ-038 The FIFO SHALL never underflow during STREAM, guaranteed by the REQ-032 entry condition.
REQ-039 WAIT_DONE on blk_wr_done_p SHALL increment the block index and blocks_written_p, then go to IDLE.
REQ-040 WAIT_DONE on blk_wr_error_p SHALL set error_p and go to ERROR; the block index SHALL NOT advance.
REQ-041 If blk_wr_done_p and blk_wr_error_p are asserted together, the error SHALL take priority.
REQ-042 ERROR SHALL be terminal until reset, with blk_wr_req_p=0 and byte_valid_p=0; the FIFO SHALL keep accepting bytes, with overflow counted normally.
REQ-043 sd_card_init_error_p=1 in any state SHALL set error_p; the FSM SHALL enter ERROR at the next state boundary (IDLE, or the end of WAIT_DONE).

Reset
REQ-044 On reset_p=1, the block SHALL synchronously enter WAIT_INIT, empty the FIFO and zero fifo_count_p, overflow_cnt_p, blocks_written_p, error_p, blk_wr_req_p, byte_valid_p and busy_p.
REQ-045 On reset, block index SHALL be START_BLOCK, blk_wr_addr_p SHALL be 0, and the latched ccs SHALL be 0.
REQ-046 A reset mid-STREAM or mid-WAIT_DONE SHALL abort immediately with no partial-block count; in-FIFO data SHALL be discarded.

Verification
REQ-047 Init with ccs=1, then 512 bytes 0x00..0xFF repeating, then ack -> blk_wr_req_p with addr 0x00000000; 512 bytes out in order; on done, blocks_written_p=1.
REQ-048 ccs=0, START_BLOCK=3, two blocks -> addresses 0x00000600 then 0x00000800.
REQ-049 Write 1030 bytes with no drain (FIFO_DEPTH=1024) -> fifo_full_p=1, overflow_cnt_p=6, fifo_count_p=1024.
REQ-050 byte_ready_p toggling 1/0 with simultaneous producer writes -> no byte loss or duplication; fifo_count_p is correct each cycle.
REQ-051 blk_wr_error_p (and done+error together) in WAIT_DONE -> error_p=1, state ERROR, block index unchanged, no further requests.
REQ-052 reset_p after 100 streamed bytes -> next cycle all outputs at reset values, state WAIT_INIT, block index START_BLOCK.
